// File: rtl/card_shoe_arbiter.sv
// Finite-shoe card source shared by the player and dealer hand loaders.
// Tracks per-rank counts and deals one rank per grant, probing upward past exhausted ranks.
module card_shoe_arbiter #(
    parameter int          DECKS = 1,
    parameter logic [7:0]  SEED  = 8'hA5
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       p_req,
    input  logic       d_req,
    input  logic       reshuffle,
    input  logic       force_en,
    input  logic [3:0] force_rank,
    output logic [3:0] card_out,
    output logic       p_gnt,
    output logic       d_gnt,
    output logic       busy,
    output logic [8:0] cards_left,
    output logic       shoe_empty
);

    localparam logic [5:0] RANK_FULL = 6'(4 * DECKS);
    localparam logic [8:0] SHOE_FULL = 9'(52 * DECKS);
    localparam logic       OWN_P     = 1'b0;
    localparam logic       OWN_D     = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Feedback for x^8+x^6+x^5+x^4+1: parity of taps 7,5,4,3.
    function automatic logic lfsr_fb(input logic [7:0] v);
        return ^(v & 8'b1011_1000);
    endfunction

    state_t     state_r, state_s;
    logic [7:0] lfsr_r, lfsr_s;
    logic [3:0] rank_ptr_r, rank_ptr_s;
    logic       owner_r, owner_s;
    logic       last_owner_r, last_owner_s;
    logic [5:0] cnt_r [1:13];
    logic [5:0] cnt_s [1:13];
    logic [8:0] cards_left_r, cards_left_s;
    logic       shoe_empty_r, shoe_empty_s;
    logic [3:0] card_out_r, card_out_s;
    logic       p_gnt_r, p_gnt_s;
    logic       d_gnt_r, d_gnt_s;
    logic       busy_r, busy_s;
    logic [7:0] lfsr_mod_s;
    logic [3:0] start_rank_s;
    logic       win_owner_s;

    // Starting rank and owner selection for a request sampled in IDLE.
    always_comb begin
        lfsr_s       = {lfsr_r[6:0], lfsr_fb(lfsr_r)};
        lfsr_mod_s   = lfsr_r % 8'd13;
        start_rank_s = lfsr_mod_s[3:0] + 4'd1;
        if (force_en) begin
            if (force_rank == 4'd0 || force_rank > 4'd13) begin
                start_rank_s = 4'd1;
            end else begin
                start_rank_s = force_rank;
            end
        end else begin
            start_rank_s = lfsr_mod_s[3:0] + 4'd1;
        end
        if (p_req && d_req) begin
            win_owner_s = ~last_owner_r;
        end else begin
            win_owner_s = d_req ? OWN_D : OWN_P;
        end
    end

    // Next-state and datapath update for the IDLE/PROBE/DONE sequence.
    always_comb begin
        state_s      = state_r;
        rank_ptr_s   = rank_ptr_r;
        owner_s      = owner_r;
        last_owner_s = last_owner_r;
        cards_left_s = cards_left_r;
        card_out_s   = card_out_r;
        p_gnt_s      = 1'b0;
        d_gnt_s      = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            cnt_s[i] = cnt_r[i];
        end
        case (state_r)
            IDLE: begin
                if (reshuffle) begin
                    for (int i = 1; i <= 13; i++) begin
                        cnt_s[i] = RANK_FULL;
                    end
                    cards_left_s = SHOE_FULL;
                end else if ((p_req || d_req) && cards_left_r != 9'd0) begin
                    owner_s    = win_owner_s;
                    rank_ptr_s = start_rank_s;
                    state_s    = PROBE;
                end else begin
                    state_s = IDLE;
                end
            end
            PROBE: begin
                if (cnt_r[rank_ptr_r] != 6'd0) begin
                    cnt_s[rank_ptr_r] = cnt_r[rank_ptr_r] - 6'd1;
                    cards_left_s      = cards_left_r - 9'd1;
                    card_out_s        = rank_ptr_r;
                    p_gnt_s           = (owner_r == OWN_P);
                    d_gnt_s           = (owner_r == OWN_D);
                    last_owner_s      = owner_r;
                    state_s           = DONE;
                end else if (rank_ptr_r >= 4'd13) begin
                    rank_ptr_s = 4'd1;
                end else begin
                    rank_ptr_s = rank_ptr_r + 4'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        shoe_empty_s = (cards_left_s == 9'd0);
        busy_s       = (state_s != IDLE);
    end

    // State register.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Shoe contents, LFSR, transaction context and registered outputs.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            lfsr_r       <= SEED;
            rank_ptr_r   <= 4'd1;
            owner_r      <= OWN_P;
            last_owner_r <= OWN_D;
            for (int i = 1; i <= 13; i++) begin
                cnt_r[i] <= RANK_FULL;
            end
            cards_left_r <= SHOE_FULL;
            shoe_empty_r <= 1'b0;
            card_out_r   <= 4'd0;
            p_gnt_r      <= 1'b0;
            d_gnt_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            lfsr_r       <= lfsr_s;
            rank_ptr_r   <= rank_ptr_s;
            owner_r      <= owner_s;
            last_owner_r <= last_owner_s;
            for (int i = 1; i <= 13; i++) begin
                cnt_r[i] <= cnt_s[i];
            end
            cards_left_r <= cards_left_s;
            shoe_empty_r <= shoe_empty_s;
            card_out_r   <= card_out_s;
            p_gnt_r      <= p_gnt_s;
            d_gnt_r      <= d_gnt_s;
            busy_r       <= busy_s;
        end
    end

    assign card_out   = card_out_r;
    assign p_gnt      = p_gnt_r;
    assign d_gnt      = d_gnt_r;
    assign busy       = busy_r;
    assign cards_left = cards_left_r;
    assign shoe_empty = shoe_empty_r;

endmodule

// File: tb/tb_card_shoe_arbiter.sv
// Directed self-checking bench for card_shoe_arbiter (DECKS=1).
module tb_card_shoe_arbiter;

    logic       slow_clock;
    logic       resetb;
    logic       p_req;
    logic       d_req;
    logic       reshuffle;
    logic       force_en;
    logic [3:0] force_rank;
    logic [3:0] card_out;
    logic       p_gnt;
    logic       d_gnt;
    logic       busy;
    logic [8:0] cards_left;
    logic       shoe_empty;

    int         checks_r = 0;
    int         errors_r = 0;
    logic [7:0] m_lfsr_r;

    card_shoe_arbiter #(.DECKS(1), .SEED(8'hA5)) dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .p_req      (p_req),
        .d_req      (d_req),
        .reshuffle  (reshuffle),
        .force_en   (force_en),
        .force_rank (force_rank),
        .card_out   (card_out),
        .p_gnt      (p_gnt),
        .d_gnt      (d_gnt),
        .busy       (busy),
        .cards_left (cards_left),
        .shoe_empty (shoe_empty)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seeded with 8'hA5.
    always @(posedge slow_clock or negedge resetb) begin
        if (!resetb) m_lfsr_r <= 8'hA5;
        else         m_lfsr_r <= {m_lfsr_r[6:0], m_lfsr_r[7] ^ m_lfsr_r[5] ^ m_lfsr_r[4] ^ m_lfsr_r[3]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        resetb    = 1'b0;
        p_req     = 1'b0;
        d_req     = 1'b0;
        reshuffle = 1'b0;
        @(negedge slow_clock);
        @(negedge slow_clock);
        resetb = 1'b1;
    endtask

    // One transaction: raise the request, wait for a grant, drop the request, confirm the pulse ends.
    task automatic do_draw(input logic who, input logic frc, input logic [3:0] fr,
                           output int lat, output logic [3:0] card, output logic [3:0] lrank);
        logic got;
        got        = 1'b0;
        lat        = 0;
        card       = 4'd0;
        lrank      = 4'((m_lfsr_r % 8'd13) + 8'd1);
        force_en   = frc;
        force_rank = fr;
        if (who) d_req = 1'b1;
        else     p_req = 1'b1;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge slow_clock);
            if (p_gnt || d_gnt) begin
                got = 1'b1;
                lat = i;
            end
        end
        chk("gnt_seen", got, 1);
        if (got) begin
            chk("gnt_owner", who ? d_gnt : p_gnt, 1);
            chk("gnt_other", who ? p_gnt : d_gnt, 0);
            card = card_out;
        end
        p_req = 1'b0;
        d_req = 1'b0;
        @(negedge slow_clock);
        chk("gnt_width", p_gnt | d_gnt, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int         lat;
        logic [3:0] card;
        logic [3:0] lr;
        logic       bad;
        logic       prev;
        int         n;
        logic       order [0:3];

        force_en   = 1'b0;
        force_rank = 4'd0;
        do_reset();
        #1;
        // Test 1: reset state, then unforced draws follow the LFSR
        chk("rst_card", card_out, 0);
        chk("rst_pgnt", p_gnt, 0);
        chk("rst_dgnt", d_gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_left", cards_left, 52);
        chk("rst_empty", shoe_empty, 0);
        do_draw(1'b0, 1'b0, 4'd0, lat, card, lr);
        chk("lfsr_seed_card", card, 10);
        do_draw(1'b1, 1'b0, 4'd0, lat, card, lr);
        chk("lfsr_next_card", card, lr);
        chk("lfsr_left", cards_left, 50);

        // Test 2: forced direct hit for the player
        do_reset();
        do_draw(1'b0, 1'b1, 4'd7, lat, card, lr);
        chk("t2_lat", lat, 2);
        chk("t2_card", card, 7);
        chk("t2_left", cards_left, 51);

        // Test 3: exhaust rank 13, then probe wraps to rank 1
        do_reset();
        for (int k = 0; k < 4; k++) begin
            do_draw(1'b1, 1'b1, 4'd13, lat, card, lr);
            chk("t3_card13", card, 13);
            chk("t3_lat13", lat, 2);
        end
        do_draw(1'b1, 1'b1, 4'd13, lat, card, lr);
        chk("t3_wrap_card", card, 1);
        chk("t3_wrap_lat", lat, 3);
        chk("t3_left", cards_left, 47);

        // Test 4: both requests held from reset, round-robin P,D,P,D
        resetb     = 1'b0;
        force_en   = 1'b1;
        force_rank = 4'd5;
        p_req      = 1'b1;
        d_req      = 1'b1;
        reshuffle  = 1'b0;
        @(negedge slow_clock);
        @(negedge slow_clock);
        resetb = 1'b1;
        bad  = 1'b0;
        prev = 1'b0;
        n    = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge slow_clock);
            if (p_gnt && d_gnt) bad = 1'b1;
            if ((p_gnt || d_gnt) && prev) bad = 1'b1;
            if (p_gnt || d_gnt) begin
                order[n] = d_gnt;
                n++;
            end
            prev = p_gnt | d_gnt;
        end
        p_req = 1'b0;
        d_req = 1'b0;
        chk("t4_count", n, 4);
        chk("t4_order0", order[0], 0);
        chk("t4_order1", order[1], 1);
        chk("t4_order2", order[2], 0);
        chk("t4_order3", order[3], 1);
        chk("t4_overlap_or_wide", bad, 0);
        @(negedge slow_clock);
        chk("t4_gnt_end", p_gnt | d_gnt, 0);
        chk("t4_card", card_out, 5);
        chk("t4_left", cards_left, 48);

        // Test 5: empty the shoe, starve a request, reshuffle releases it
        do_reset();
        for (int r = 1; r <= 13; r++) begin
            for (int k = 0; k < 4; k++) begin
                do_draw(k[0], 1'b1, 4'(r), lat, card, lr);
                chk("t5_card", card, r);
            end
        end
        chk("t5_left0", cards_left, 0);
        chk("t5_empty", shoe_empty, 1);
        force_rank = 4'd4;
        p_req      = 1'b1;
        bad        = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge slow_clock);
            if (p_gnt || d_gnt || busy) bad = 1'b1;
        end
        chk("t5_starved", bad, 0);
        chk("t5_empty_hold", shoe_empty, 1);
        reshuffle = 1'b1;
        @(negedge slow_clock);
        reshuffle = 1'b0;
        chk("t5_refill_left", cards_left, 52);
        chk("t5_refill_empty", shoe_empty, 0);
        chk("t5_refill_busy", busy, 0);
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            @(negedge slow_clock);
            if (p_gnt) n = i;
        end
        chk("t5_lat", n, 2);
        chk("t5_card", card_out, 4);
        p_req = 1'b0;
        @(negedge slow_clock);
        chk("t5_left", cards_left, 51);

        // Test 6: reset while probing drops the request
        force_rank = 4'd13;
        p_req      = 1'b1;
        @(negedge slow_clock);
        chk("t6_busy", busy, 1);
        #2;
        resetb = 1'b0;
        #1;
        chk("t6_left", cards_left, 52);
        chk("t6_busy_rst", busy, 0);
        chk("t6_card_rst", card_out, 0);
        p_req = 1'b0;
        bad   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge slow_clock);
            if (i == 1) resetb = 1'b1;
            if (p_gnt || d_gnt) bad = 1'b1;
        end
        chk("t6_no_gnt", bad, 0);
        do_draw(1'b0, 1'b1, 4'd15, lat, card, lr);
        chk("t6_card15", card, 1);
        chk("t6_lat", lat, 2);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
